// File: rtl/hrm_io_bridge.sv
// rtl/hrm_io_bridge.sv - UART byte-stream adapter around the HRM CPU INBOX/OUTBOX ports
// Inbound: staging FIFO drains into INBOX. Outbound: OUTBOX drains into a valid/ready byte stream.
module hrm_io_bridge #(
   parameter int LGDEPTH = 2
) (
   input  logic               clk,
   input  logic               i_rst_n,
   input  logic               i_rx_valid,
   input  logic [7:0]         i_rx_data,
   input  logic               i_ovf_clr,
   output logic               o_cpu_in_wr,
   output logic [7:0]         o_cpu_in_data,
   input  logic               i_cpu_in_full,
   output logic               o_cpu_out_rd,
   input  logic [7:0]         i_cpu_out_data,
   input  logic               i_cpu_out_empty,
   output logic               o_tx_valid,
   output logic [7:0]         o_tx_data,
   input  logic               i_tx_ready,
   output logic [LGDEPTH:0]   o_rx_count,
   output logic               o_rx_overflow
);

   localparam int DEPTH = 1 << LGDEPTH;
   localparam logic [LGDEPTH:0] FULL_CNT = (LGDEPTH+1)'(DEPTH);

   typedef enum logic {IN_IDLE, IN_WAIT} in_state_t;
   typedef enum logic [1:0] {OUT_IDLE, OUT_POP, OUT_SEND} out_state_t;

   in_state_t  in_state, in_next;
   out_state_t out_state, out_next;

   logic [7:0]         mem [DEPTH];
   logic [LGDEPTH-1:0] wr_ptr, rd_ptr;
   logic [LGDEPTH:0]   count;
   logic               pop, push, drop, out_take;

   // A pop frees a slot in the same edge, so a full FIFO can still accept a byte.
   assign pop      = (in_state == IN_IDLE) && (count != '0) && !i_cpu_in_full;
   assign push     = i_rx_valid && ((count != FULL_CNT) || pop);
   assign drop     = i_rx_valid && (count == FULL_CNT) && !pop;
   assign out_take = (out_state == OUT_IDLE) && !i_cpu_out_empty;
   assign o_rx_count = count;

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= i_rx_data;
   end

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         o_rx_overflow <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (drop)
            o_rx_overflow <= 1'b1;
         else if (i_ovf_clr)
            o_rx_overflow <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n)
         in_state <= IN_IDLE;
      else
         in_state <= in_next;
   end

   always_comb begin
      in_next = in_state;
      unique case (in_state)
         IN_IDLE: if (pop) in_next = IN_WAIT;
         IN_WAIT: in_next = IN_IDLE;
         default: in_next = IN_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_cpu_in_wr   <= 1'b0;
         o_cpu_in_data <= '0;
      end else begin
         o_cpu_in_wr <= pop;
         if (pop)
            o_cpu_in_data <= mem[rd_ptr];
      end
   end

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n)
         out_state <= OUT_IDLE;
      else
         out_state <= out_next;
   end

   // The empty flag is only looked at in OUT_IDLE, two edges after the pop.
   always_comb begin
      out_next = out_state;
      unique case (out_state)
         OUT_IDLE: if (out_take) out_next = OUT_POP;
         OUT_POP:  out_next = OUT_SEND;
         OUT_SEND: if (i_tx_ready) out_next = OUT_IDLE;
         default:  out_next = OUT_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_cpu_out_rd <= 1'b0;
         o_tx_valid   <= 1'b0;
         o_tx_data    <= '0;
      end else begin
         o_cpu_out_rd <= out_take;
         if (out_take)
            o_tx_data <= i_cpu_out_data;
         o_tx_valid <= (out_state == OUT_POP) || ((out_state == OUT_SEND) && !i_tx_ready);
      end
   end

endmodule

// File: tb/tb_hrm_io_bridge.sv
// tb/tb_hrm_io_bridge.sv - directed and concurrent-traffic bench for hrm_io_bridge
module tb_hrm_io_bridge;

   logic       clk = 1'b0;
   logic       i_rst_n, i_rx_valid, i_ovf_clr, i_cpu_in_full;
   logic       i_cpu_out_empty, i_tx_ready;
   logic [7:0] i_rx_data, i_cpu_out_data;
   logic       o_cpu_in_wr, o_cpu_out_rd, o_tx_valid, o_rx_overflow;
   logic [7:0] o_cpu_in_data, o_tx_data;
   logic [2:0] o_rx_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   hrm_io_bridge #(.LGDEPTH(2)) dut (
      .clk(clk), .i_rst_n(i_rst_n),
      .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data), .i_ovf_clr(i_ovf_clr),
      .o_cpu_in_wr(o_cpu_in_wr), .o_cpu_in_data(o_cpu_in_data), .i_cpu_in_full(i_cpu_in_full),
      .o_cpu_out_rd(o_cpu_out_rd), .i_cpu_out_data(i_cpu_out_data), .i_cpu_out_empty(i_cpu_out_empty),
      .o_tx_valid(o_tx_valid), .o_tx_data(o_tx_data), .i_tx_ready(i_tx_ready),
      .o_rx_count(o_rx_count), .o_rx_overflow(o_rx_overflow)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   logic [7:0] exp_in[$];
   logic [7:0] exp_tx[$];
   logic [7:0] outbox[$];
   logic [7:0] rx_bytes[12];
   int rx_sent, in_got, tx_got, rd_cnt, gap;

   initial begin
      i_rst_n = 1'b0; i_rx_valid = 1'b0; i_rx_data = 8'h00; i_ovf_clr = 1'b0;
      i_cpu_in_full = 1'b0; i_cpu_out_empty = 1'b1; i_cpu_out_data = 8'h00; i_tx_ready = 1'b0;
      tick(); tick();
      chk("rst_in_wr", o_cpu_in_wr, 0);
      chk("rst_in_data", o_cpu_in_data, 0);
      chk("rst_out_rd", o_cpu_out_rd, 0);
      chk("rst_tx_valid", o_tx_valid, 0);
      chk("rst_tx_data", o_tx_data, 0);
      chk("rst_count", o_rx_count, 0);
      chk("rst_ovf", o_rx_overflow, 0);
      i_rst_n = 1'b1;
      tick();

      // single byte latency
      i_rx_valid = 1'b1; i_rx_data = 8'h41;
      tick();
      i_rx_valid = 1'b0;
      chk("t1_count1", o_rx_count, 1);
      chk("t1_wr_early", o_cpu_in_wr, 0);
      tick();
      chk("t1_wr", o_cpu_in_wr, 1);
      chk("t1_data", o_cpu_in_data, 8'h41);
      chk("t1_count0", o_rx_count, 0);
      tick();
      chk("t1_wr_drop", o_cpu_in_wr, 0);

      // INBOX full: fill staging, overflow on the fifth byte
      i_cpu_in_full = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         i_rx_valid = 1'b1; i_rx_data = 8'(i);
         tick();
         chk("t2_count", o_rx_count, (i < 4) ? i : 4);
         chk("t2_ovf", o_rx_overflow, (i >= 5) ? 1 : 0);
         chk("t2_no_wr", o_cpu_in_wr, 0);
      end
      i_rx_valid = 1'b0; i_cpu_in_full = 1'b0;
      tick();
      chk("t2_wr0", o_cpu_in_wr, 1);
      chk("t2_data0", o_cpu_in_data, 8'h01);
      for (int k = 1; k <= 3; k++) begin
         tick();
         chk("t2_gap", o_cpu_in_wr, 0);
         tick();
         chk("t2_wr", o_cpu_in_wr, 1);
         chk("t2_data", o_cpu_in_data, 8'(k + 1));
      end
      tick();
      chk("t2_wr_end", o_cpu_in_wr, 0);
      chk("t2_count_end", o_rx_count, 0);
      chk("t2_ovf_held", o_rx_overflow, 1);
      i_ovf_clr = 1'b1;
      tick();
      i_ovf_clr = 1'b0;
      chk("t2_ovf_clr", o_rx_overflow, 0);

      // full staging: simultaneous clear+overflow, then push during pop, across pointer wrap
      i_cpu_in_full = 1'b1;
      for (int i = 0; i < 4; i++) begin
         i_rx_valid = 1'b1; i_rx_data = 8'hA0 + 8'(i);
         tick();
      end
      chk("t3_count_full", o_rx_count, 4);
      i_rx_data = 8'hEE; i_ovf_clr = 1'b1;
      tick();
      chk("t3_set_wins", o_rx_overflow, 1);
      chk("t3_count_drop", o_rx_count, 4);
      i_rx_valid = 1'b0;
      tick();
      i_ovf_clr = 1'b0;
      chk("t3_ovf_clr", o_rx_overflow, 0);
      i_cpu_in_full = 1'b0; i_rx_valid = 1'b1; i_rx_data = 8'hA4;
      tick();
      i_rx_valid = 1'b0;
      chk("t3_count_same", o_rx_count, 4);
      chk("t3_no_ovf", o_rx_overflow, 0);
      chk("t3_wr0", o_cpu_in_wr, 1);
      chk("t3_data0", o_cpu_in_data, 8'hA0);
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk("t3_gap", o_cpu_in_wr, 0);
         tick();
         chk("t3_wr", o_cpu_in_wr, 1);
         chk("t3_data", o_cpu_in_data, 8'hA0 + 8'(k));
      end
      tick();
      chk("t3_count_end", o_rx_count, 0);

      // outbound with stalled transmitter
      i_cpu_out_empty = 1'b0; i_cpu_out_data = 8'h7F;
      tick();
      chk("t4_rd1", o_cpu_out_rd, 1);
      chk("t4_valid_early", o_tx_valid, 0);
      i_cpu_out_data = 8'h80;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("t4_rd_once", o_cpu_out_rd, 0);
         chk("t4_valid_hold", o_tx_valid, 1);
         chk("t4_data_hold", o_tx_data, 8'h7F);
      end
      i_tx_ready = 1'b1;
      tick();
      i_tx_ready = 1'b0;
      chk("t4_valid_done", o_tx_valid, 0);
      tick();
      chk("t4_rd2", o_cpu_out_rd, 1);
      i_cpu_out_empty = 1'b1;
      tick();
      chk("t4_rd2_once", o_cpu_out_rd, 0);
      chk("t4_valid2", o_tx_valid, 1);
      chk("t4_data2", o_tx_data, 8'h80);
      i_tx_ready = 1'b1;
      tick();
      i_tx_ready = 1'b0;
      chk("t4_valid2_done", o_tx_valid, 0);
      tick();
      chk("t4_no_rd", o_cpu_out_rd, 0);

      // async reset mid-transfer
      i_cpu_in_full = 1'b1; i_rx_valid = 1'b1; i_rx_data = 8'hB1;
      i_cpu_out_empty = 1'b0; i_cpu_out_data = 8'h55;
      tick();
      i_rx_data = 8'hB2; i_cpu_out_empty = 1'b1;
      tick();
      i_rx_valid = 1'b0;
      chk("t5_pre_count", o_rx_count, 2);
      chk("t5_pre_valid", o_tx_valid, 1);
      #2 i_rst_n = 1'b0;
      #1;
      chk("t5_valid0", o_tx_valid, 0);
      chk("t5_data0", o_tx_data, 0);
      chk("t5_rd0", o_cpu_out_rd, 0);
      chk("t5_wr0", o_cpu_in_wr, 0);
      chk("t5_in_data0", o_cpu_in_data, 0);
      chk("t5_count0", o_rx_count, 0);
      chk("t5_ovf0", o_rx_overflow, 0);
      tick();
      i_rst_n = 1'b1; i_cpu_in_full = 1'b0; i_tx_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("t5_no_wr", o_cpu_in_wr, 0);
         chk("t5_no_valid", o_tx_valid, 0);
         chk("t5_no_rd", o_cpu_out_rd, 0);
      end

      // both directions concurrently
      for (int i = 0; i < 12; i++) begin
         rx_bytes[i] = 8'($urandom);
         outbox.push_back(8'($urandom));
         exp_tx.push_back(outbox[i]);
      end
      rx_sent = 0; in_got = 0; tx_got = 0; rd_cnt = 0; gap = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (o_cpu_in_wr) begin
            chk("t6_in_expected", exp_in.size() > 0, 1);
            if (exp_in.size() > 0) chk("t6_in_data", o_cpu_in_data, exp_in.pop_front());
            in_got++;
         end
         if (o_cpu_out_rd) begin
            rd_cnt++;
            if (outbox.size() > 0) void'(outbox.pop_front());
         end
         i_cpu_out_empty = (outbox.size() == 0);
         i_cpu_out_data  = (outbox.size() > 0) ? outbox[0] : 8'h00;
         i_tx_ready = 1'($urandom_range(0, 1));
         if (o_tx_valid && i_tx_ready) begin
            chk("t6_tx_expected", exp_tx.size() > 0, 1);
            if (exp_tx.size() > 0) chk("t6_tx_data", o_tx_data, exp_tx.pop_front());
            tx_got++;
         end
         if (gap == 0 && rx_sent < 12) begin
            i_rx_valid = 1'b1; i_rx_data = rx_bytes[rx_sent];
            exp_in.push_back(rx_bytes[rx_sent]);
            rx_sent++;
            gap = $urandom_range(1, 3);
         end else begin
            i_rx_valid = 1'b0;
            if (gap > 0) gap--;
         end
         if (in_got == 12 && tx_got == 12) break;
         tick();
      end
      i_rx_valid = 1'b0; i_tx_ready = 1'b0;
      tick(); tick(); tick();
      chk("t6_in_total", in_got, 12);
      chk("t6_tx_total", tx_got, 12);
      chk("t6_pop_total", rd_cnt, 12);
      chk("t6_no_ovf", o_rx_overflow, 0);
      chk("t6_count_end", o_rx_count, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hrm_io_bridge.md
Name: hrm_io_bridge

Overview:
- Byte-stream adapter that sits directly around the HRM CPU's INBOX/OUTBOX FIFO ports.
- Inbound: accepts bytes from a UART receiver, which has no backpressure. Buffers them in a small staging FIFO and pushes them into the CPU INBOX (cpu_in_data/cpu_in_wr), respecting cpu_in_full.
- Outbound: drains the CPU OUTBOX (cpu_out_data/cpu_out_rd/cpu_out_empty) into a valid/ready byte interface feeding a UART transmitter.

Parameters:
LGDEPTH, 2, log2 of staging FIFO depth (DEPTH = 2**LGDEPTH = 4 entries).

Ports:
clk  input  1  system clock; all state on rising edge.
i_rst_n  input  1  reset, asynchronous, active-low.
i_rx_valid  input  1  one-cycle strobe: i_rx_data holds a received byte.
i_rx_data  input  8  received byte.
i_ovf_clr  input  1  clears o_rx_overflow.
o_cpu_in_wr  output  1  push strobe to CPU INBOX (drives cpu_in_wr).
o_cpu_in_data  output  8  byte to CPU INBOX (drives cpu_in_data).
i_cpu_in_full  input  1  CPU INBOX full (from cpu_in_full).
o_cpu_out_rd  output  1  pop strobe to CPU OUTBOX (drives cpu_out_rd).
i_cpu_out_data  input  8  OUTBOX head byte (from cpu_out_data), valid while not empty.
i_cpu_out_empty  input  1  OUTBOX empty (from cpu_out_empty).
o_tx_valid  output  1  o_tx_data valid for transmitter.
o_tx_data  output  8  byte to transmitter.
i_tx_ready  input  1  transmitter accepts the byte when high with o_tx_valid.
o_rx_count  output  LGDEPTH+1  staging FIFO occupancy, 0..DEPTH.
o_rx_overflow  output  1  sticky: a received byte was dropped.

Behaviour:
- Reset (i_rst_n=0, async) takes effect immediately, even mid-operation:
  - all outputs go to 0;
  - staging FIFO is emptied (pointers and count = 0) and any in-flight byte is discarded;
  - both FSMs go to IDLE.
- All outputs are registered.
- Staging FIFO: circular buffer, DEPTH entries, read/write pointers LGDEPTH bits wide that wrap modulo DEPTH.
  - A push occurs on i_rx_valid when count < DEPTH, or when a pop happens in the same cycle.
  - With push and pop in the same cycle, count is unchanged.
  - If i_rx_valid arrives while count == DEPTH and there is no pop that cycle: the byte is dropped, FIFO is unchanged, o_rx_overflow <= 1.
  - o_rx_overflow stays set until i_ovf_clr. If i_ovf_clr and an overflow occur in the same cycle, the set wins.
- Inbound FSM (IN_IDLE, IN_WAIT):
  - IN_IDLE: if count > 0 and !i_cpu_in_full, then:
    - pop the head;
    - o_cpu_in_data <= head and o_cpu_in_wr <= 1 for exactly one cycle;
    - go to IN_WAIT.
  - IN_WAIT: o_cpu_in_wr <= 0, go to IN_IDLE. This one-cycle wait lets the INBOX full flag update.
  - Maximum inbound rate is one byte per 2 cycles.
  - Latency: a byte pushed at edge k into an empty FIFO, with INBOX not full, gives o_cpu_in_wr high after edge k+1.
  - While i_cpu_in_full = 1, bytes accumulate in staging; overflow handling applies once it fills.
- Outbound FSM (OUT_IDLE, OUT_POP, OUT_SEND):
  - OUT_IDLE: if !i_cpu_out_empty, then:
    - o_tx_data <= i_cpu_out_data and o_cpu_out_rd <= 1 for one cycle;
    - go to OUT_POP.
  - OUT_POP: o_cpu_out_rd <= 0, o_tx_valid <= 1, go to OUT_SEND.
  - OUT_SEND: hold o_tx_valid and o_tx_data stable until i_tx_ready is high. On that edge o_tx_valid <= 0 and go to OUT_IDLE.
  - i_tx_ready is ignored outside OUT_SEND. There is exactly one pop per transmitted byte, and bytes are sent in OUTBOX order.
  - Minimum 3 cycles per byte. The empty flag is not re-sampled until 2 cycles after the pop, so a stale empty flag cannot cause a double pop.
- Inbound and outbound paths are fully independent and may be active in the same cycle.

Test Plan:
1. Reset, then i_rx_valid with 0x41 while i_cpu_in_full = 0: o_cpu_in_wr pulses exactly one cycle with o_cpu_in_data = 0x41, 2 cycles after the strobe; o_rx_count returns to 0.
2. Hold i_cpu_in_full = 1 and strobe 0x01..0x06:
   - o_rx_count reaches 4 and o_rx_overflow = 1 after the 5th byte;
   - release full: INBOX receives 0x01,0x02,0x03,0x04 in order, at one write per 2 cycles;
   - i_ovf_clr clears the flag.
3. Staging full (count = 4) with i_cpu_in_full = 0: an i_rx_valid in the same cycle as a pop is accepted, count stays 4 and no overflow. Then check order through pointer wrap-around.
4. OUTBOX presents 0x7F then 0x80 (i_cpu_out_empty = 0) with i_tx_ready = 0:
   - exactly one o_cpu_out_rd pulse;
   - o_tx_valid = 1 and o_tx_data = 0x7F held stable;
   - raising i_tx_ready for one cycle delivers 0x7F, then 0x80 follows with a second single pop.
5. Assert i_rst_n = 0 asynchronously mid-transfer (OUT_SEND, count = 2): all outputs drop to 0 immediately and o_rx_count = 0. After release, no stale byte is emitted on either side.
6. Run both directions concurrently, with a random rx strobe every ≥ 2 cycles and random i_tx_ready: all bytes are delivered in order, with no drop while count < 4 and no duplicate pops.
